// File: rtl/mem_copy_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_copy_engine
// Purpose  : Bulk-copy master for the four-bank segmented unified memory.
//            Copies `length` consecutive words from (src_bank, src_base) to
//            (dst_bank, dst_base), one word every two cycles (RD then WR).
//            Software drives start and observes busy/done/err.
// Ports    :
//   clk, rst_n              clock (rising edge), async active-low reset
//   start, abort            request a copy / stop an in-progress copy
//   src_bank, dst_bank      bank indices 0..3
//   src_base, dst_base      start word addresses
//   length                  number of words to copy
//   busy, done, err         status: copying / one-cycle completion / error
//   mem_a, mem_wd, mem_we   packed per-bank address, write data, write enable
//   mem_rd                  packed per-bank read data (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module mem_copy_engine #(
  parameter int WIDTH = 32,
  parameter int LENW  = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         src_bank,
  input  logic [1:0]         dst_bank,
  input  logic [WIDTH-1:0]   src_base,
  input  logic [WIDTH-1:0]   dst_base,
  input  logic [LENW-1:0]    length,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [4*WIDTH-1:0] mem_a,
  output logic [4*WIDTH-1:0] mem_wd,
  output logic [3:0]         mem_we,
  input  logic [4*WIDTH-1:0] mem_rd
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t           r_state;
  logic [1:0]       r_src_bank;
  logic [1:0]       r_dst_bank;
  logic [WIDTH-1:0] r_src_base;
  logic [WIDTH-1:0] r_dst_base;
  logic [LENW-1:0]  r_len;
  logic [LENW-1:0]  r_idx;
  logic [WIDTH-1:0] r_data;
  logic             r_err;

  // Fixed bank depths in words.
  function automatic logic [WIDTH:0] bank_depth(input logic [1:0] b);
    case (b)
      2'd0:    bank_depth = (WIDTH+1)'(1024);
      2'd1:    bank_depth = (WIDTH+1)'(32);
      2'd2:    bank_depth = (WIDTH+1)'(1024);
      default: bank_depth = (WIDTH+1)'(512);
    endcase
  endfunction

  // Range sums carry one extra bit so a wrapping base+length is rejected.
  logic [WIDTH:0]   w_len_ext;
  logic [WIDTH:0]   w_src_end;
  logic [WIDTH:0]   w_dst_end;
  logic             w_range_err;
  logic [WIDTH-1:0] w_src_addr;
  logic [WIDTH-1:0] w_dst_addr;
  logic [LENW-1:0]  w_idx_nxt;
  logic [WIDTH-1:0] w_rd_lane;

  assign w_len_ext   = {{(WIDTH+1-LENW){1'b0}}, length};
  assign w_src_end   = {1'b0, src_base} + w_len_ext;
  assign w_dst_end   = {1'b0, dst_base} + w_len_ext;
  assign w_range_err = (w_src_end > bank_depth(src_bank)) ||
                       (w_dst_end > bank_depth(dst_bank));

  assign w_src_addr  = r_src_base + WIDTH'(r_idx);
  assign w_dst_addr  = r_dst_base + WIDTH'(r_idx);
  assign w_idx_nxt   = r_idx + LENW'(1);
  assign w_rd_lane   = mem_rd[r_src_bank*WIDTH +: WIDTH];

  // Memory lanes decode purely from the state register, so an async reset
  // drops mem_we in the same cycle it is asserted.
  always_comb begin
    mem_a  = '0;
    mem_wd = '0;
    mem_we = '0;
    case (r_state)
      S_RD: begin
        mem_a[r_src_bank*WIDTH +: WIDTH] = w_src_addr;
      end
      S_WR: begin
        mem_a[r_dst_bank*WIDTH +: WIDTH]  = w_dst_addr;
        mem_wd[r_dst_bank*WIDTH +: WIDTH] = r_data;
        mem_we[r_dst_bank]                = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (r_state == S_RD) || (r_state == S_WR);
  assign done = (r_state == S_FIN);
  assign err  = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_src_bank <= '0;
      r_dst_bank <= '0;
      r_src_base <= '0;
      r_dst_base <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_data     <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src_bank <= src_bank;
            r_dst_bank <= dst_bank;
            r_src_base <= src_base;
            r_dst_base <= dst_base;
            r_len      <= length;
            r_idx      <= '0;
            r_err      <= 1'b0;
            if (length == '0) begin
              r_state <= S_FIN;
            end else if (w_range_err) begin
              r_err   <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_state <= S_RD;
            end
          end
        end
        S_RD: begin
          if (abort) begin
            r_err   <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_data  <= w_rd_lane;
            r_state <= S_WR;
          end
        end
        S_WR: begin
          // The write of this cycle commits at this edge even on abort.
          r_idx <= w_idx_nxt;
          if (abort) begin
            r_err   <= 1'b1;
            r_state <= S_FIN;
          end else if (w_idx_nxt == r_len) begin
            r_state <= S_FIN;
          end else begin
            r_state <= S_RD;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_copy_engine
// Purpose  : Directed self-checking bench for mem_copy_engine with a
//            behavioural four-bank memory (depths 1024/32/1024/512, bank2
//            5 bits wide, zero-extended on read).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_copy_engine;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [1:0]   src_bank;
  logic [1:0]   dst_bank;
  logic [W-1:0] src_base;
  logic [W-1:0] dst_base;
  logic [10:0]  length;
  logic         busy;
  logic         done;
  logic         err;
  logic [4*W-1:0] mem_a;
  logic [4*W-1:0] mem_wd;
  logic [3:0]     mem_we;
  logic [4*W-1:0] mem_rd;

  mem_copy_engine #(.WIDTH(W), .LENW(11)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .src_bank (src_bank),
    .dst_bank (dst_bank),
    .src_base (src_base),
    .dst_base (dst_base),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd),
    .mem_we   (mem_we),
    .mem_rd   (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory
  logic [31:0] b0 [1024];
  logic [31:0] b1 [32];
  logic [4:0]  b2 [1024];
  logic [31:0] b3 [512];
  int wr_total;
  int multihot;

  logic [31:0] a0, a1, a2, a3;
  assign a0 = mem_a[31:0];
  assign a1 = mem_a[63:32];
  assign a2 = mem_a[95:64];
  assign a3 = mem_a[127:96];

  assign mem_rd[31:0]   = (a0 < 32'd1024) ? b0[a0[9:0]] : 32'h0;
  assign mem_rd[63:32]  = (a1 < 32'd32)   ? b1[a1[4:0]] : 32'h0;
  assign mem_rd[95:64]  = (a2 < 32'd1024) ? {27'h0, b2[a2[9:0]]} : 32'h0;
  assign mem_rd[127:96] = (a3 < 32'd512)  ? b3[a3[8:0]] : 32'h0;

  // Single process owns the memory: preload, then commit writes each edge.
  initial begin
    wr_total = 0;
    multihot = 0;
    for (int i = 0; i < 1024; i++) begin b0[i] = 32'h0; b2[i] = 5'h0; end
    for (int i = 0; i < 32; i++)  b1[i] = 32'h0;
    for (int i = 0; i < 512; i++) b3[i] = 32'h55;
    for (int i = 0; i < 4; i++)   b0[16'h10 + i] = 32'hA0 + i;
    b0[16'h1F] = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      b0[16'h40 + i]  = 32'h100 + i;
      b0[16'h200 + i] = 32'hDEAD_BEEF;
    end
    forever begin
      @(posedge clk);
      if ($countones(mem_we) > 1) multihot <= multihot + 1;
      if (|mem_we) wr_total <= wr_total + 1;
      if (mem_we[0] && a0 < 32'd1024) b0[a0[9:0]] <= mem_wd[31:0];
      if (mem_we[1] && a1 < 32'd32)   b1[a1[4:0]] <= mem_wd[63:32];
      if (mem_we[2] && a2 < 32'd1024) b2[a2[9:0]] <= mem_wd[68:64];
      if (mem_we[3] && a3 < 32'd512)  b3[a3[8:0]] <= mem_wd[127:96];
    end
  end

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the caller at the negedge of the first cycle after acceptance.
  task automatic start_copy(input logic [1:0] sb, input logic [1:0] db,
                            input logic [31:0] sa, input logic [31:0] da,
                            input logic [10:0] len);
    @(negedge clk);
    src_bank = sb; dst_bank = db; src_base = sa; dst_base = da; length = len;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the cycle number (1 = first after acceptance) with done high.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) cyc = -1;
  endtask

  int cyc;
  int w0;

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    src_bank = '0; dst_bank = '0; src_base = '0; dst_base = '0; length = '0;

    // Reset state
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_we", mem_we, 4'h0);
    check("rst_a", mem_a, 128'h0);
    check("rst_wd", mem_wd, 128'h0);
    @(negedge clk); rst_n = 1'b1;

    // bank0 0x10 -> bank3 0x100, length 4
    w0 = wr_total;
    start_copy(2'd0, 2'd3, 32'h10, 32'h100, 11'd4);
    check("t1_busy", busy, 1'b1);
    wait_done(cyc);
    check("t1_done_cycle", cyc, 9);
    check("t1_busy_fin", busy, 1'b0);
    check("t1_err", err, 1'b0);
    check("t1_writes", wr_total - w0, 4);
    for (int i = 0; i < 4; i++) check("t1_data", b3[9'h100 + i], 32'hA0 + i);
    check("t1_onehot", multihot, 0);
    @(negedge clk);
    check("t1_done_pulse", done, 1'b0);

    // bank1 base 30 length 4: out of range
    w0 = wr_total;
    start_copy(2'd1, 2'd0, 32'd30, 32'h0, 11'd4);
    wait_done(cyc);
    check("t2_done_cycle", cyc, 1);
    check("t2_err", err, 1'b1);
    @(negedge clk);
    check("t2_writes", wr_total - w0, 0);
    check("t2_err_sticky", err, 1'b1);

    // length 0
    w0 = wr_total;
    start_copy(2'd0, 2'd0, 32'h10, 32'h20, 11'd0);
    wait_done(cyc);
    check("t3_done_cycle", cyc, 1);
    check("t3_err", err, 1'b0);
    @(negedge clk);
    check("t3_writes", wr_total - w0, 0);

    // bank0[0x1F] -> bank2[5] (truncate), then bank2[5] -> bank1[0] (zero-extend)
    start_copy(2'd0, 2'd2, 32'h1F, 32'd5, 11'd1);
    wait_done(cyc);
    check("t4_done_cycle", cyc, 3);
    check("t4_b2", b2[5], 5'h1F);
    start_copy(2'd2, 2'd1, 32'd5, 32'd0, 11'd1);
    wait_done(cyc);
    check("t4_err", err, 1'b0);
    check("t4_b1", b1[0], 32'h0000_001F);

    // length 8 with abort during the WR cycle of word 2 (cycle 6)
    w0 = wr_total;
    start_copy(2'd0, 2'd0, 32'h40, 32'h200, 11'd8);
    repeat (5) @(negedge clk);
    check("t5_we_wr2", mem_we, 4'b0001);
    check("t5_addr_wr2", mem_a[31:0], 32'h202);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_done", done, 1'b1);
    check("t5_err", err, 1'b1);
    check("t5_writes", wr_total - w0, 3);
    check("t5_w0", b0[16'h200], 32'h100);
    check("t5_w2", b0[16'h202], 32'h102);
    check("t5_w3", b0[16'h203], 32'hDEAD_BEEF);
    check("t5_w7", b0[16'h207], 32'hDEAD_BEEF);

    // length 8, reset dropped during WR of word 1 (cycle 4)
    w0 = wr_total;
    start_copy(2'd0, 2'd3, 32'h40, 32'h0, 11'd8);
    repeat (3) @(negedge clk);
    check("t6_we_before", mem_we, 4'b1000);
    rst_n = 1'b0;
    #1;
    check("t6_we_reset", mem_we, 4'h0);
    check("t6_busy_reset", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_writes", wr_total - w0, 1);
    check("t6_b3_0", b3[0], 32'h100);
    check("t6_b3_1", b3[1], 32'h55);
    check("t6_err", err, 1'b0);
    start_copy(2'd0, 2'd1, 32'h10, 32'd4, 11'd2);
    wait_done(cyc);
    check("t6_done_cycle", cyc, 5);
    check("t6_err_after", err, 1'b0);
    check("t6_b1_4", b1[4], 32'hA0);
    check("t6_b1_5", b1[5], 32'hA1);
    check("t6_onehot", multihot, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Initiator-side block for the four-bank segmented unified memory.
- Copies a run of consecutive words from a source bank/address to a destination bank/address by driving the memory's packed address, write-data and per-bank write-enable lanes. It reads back through the memory's combinational read lanes.
- Sits beside the pipeline as a bulk-transfer master, used for table loads and buffer moves. Software starts it with a start/busy/done handshake.

Parameters:
- WIDTH, 32, lane width; the memory ports are 4*WIDTH wide, with bank k on bits [WIDTH*(k+1)-1 : WIDTH*k].
- LENW, 11, width of the length field (max 1024 words).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a copy; sampled only in IDLE.
- abort  in  1  stop an in-progress copy.
- src_bank  in  2  source bank index 0..3.
- dst_bank  in  2  destination bank index 0..3.
- src_base  in  WIDTH  source start word address.
- dst_base  in  WIDTH  destination start word address.
- length  in  LENW  number of words to copy.
- busy  out  1  high in RD/WR states.
- done  out  1  one-cycle completion pulse.
- err  out  1  range error or abort; sticky until next accepted start.
- mem_a  out  4*WIDTH  packed per-bank addresses.
- mem_wd  out  4*WIDTH  packed per-bank write data.
- mem_we  out  4  per-bank write enables.
- mem_rd  in  4*WIDTH  packed per-bank read data (combinational from mem_a).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, err=0, mem_we=0, mem_a=0, mem_wd=0. Internal counters and data register are cleared.
- Bank depths are fixed: bank0 1024, bank1 32, bank2 1024, bank3 512. Bank2 stores only 5 bits.
- FSM states: IDLE, RD, WR, FIN.
- IDLE, on start=1 at an edge:
  - The engine latches all request fields and sets err=0.
  - If length=0, go to FIN.
  - Else if src_base+length > depth(src_bank) or dst_base+length > depth(dst_bank), go to FIN with err=1 and perform no memory access.
  - Else go to RD with idx=0.
  - The range sum is computed at WIDTH+1 bits, so overflow counts as out of range.
- RD:
  - Drive lane src_bank with src_base+idx. All other lanes of mem_a are 0 and mem_we=0.
  - At the edge, capture lane src_bank of mem_rd into the data register, then go to WR.
- WR:
  - Drive lane dst_bank of mem_a with dst_base+idx and lane dst_bank of mem_wd with the data register.
  - Drive mem_we one-hot at dst_bank. Other lanes are 0.
  - At the edge the write commits; idx increments. If idx+1 == length go to FIN, else go to RD.
- FIN: done=1 and busy=0 for exactly one cycle, then return to IDLE.
- Two cycles per word. If start is accepted at edge E0, done is high during the cycle after edge E0+2*length. For length=0 or a range error, done is high in the cycle after E0.
- Data width rules:
  - A read from bank2 is zero-extended by the memory. The engine passes the value through unchanged.
  - A write to bank2 keeps only bits [4:0], truncated by the memory.
- Copy order is ascending address. A same-bank copy with overlapping ranges and dst_base > src_base propagates already-overwritten words. This is defined behaviour, not an error.
- abort=1 sampled in RD or WR:
  - The write scheduled in a WR cycle still commits at that edge.
  - Next state is FIN with err=1; no further accesses.
  - abort in IDLE or FIN is ignored.
- start while busy or in FIN is ignored and not queued.
- mem_we and lane outputs decode combinationally from state. An async reset mid-write therefore deasserts mem_we immediately, and no partial state survives.
- err holds its value through IDLE until the next accepted start.

Test Plan:
- Memory preloaded with bank0[0x10..0x13]=0xA0..0xA3; copy bank0 0x10 → bank3 0x100, length 4. Required: 4 writes at bank3 0x100..0x103 with data 0xA0..0xA3. done is high in cycle 9 after acceptance, err=0, and mem_we never has more than one bit set.
- Copy bank1 base 30, length 4, to bank0. Required: no mem_we activity, err=1, done one cycle after acceptance.
- length=0. Required: done pulse in the next cycle, err=0, zero writes.
- Copy bank0 word 0x1F=0xFFFF_FFFF to bank2 addr 5. Required: bank2[5] reads 0x1F; then copying bank2[5] back to bank1[0] gives 0x0000_001F.
- Copy length 8; assert abort in the WR cycle of word 2. Required: words 0..2 written, words 3..7 untouched, err=1, done pulse.
- Copy length 8; drop rst_n during a WR cycle. Required: mem_we=0 the same cycle, busy=0. After release, a start with new parameters executes normally.
